// File: rtl/tile_config_loader.sv
// Byte-serial configuration loader: frames a sync byte plus 19 payload bytes into a
// 146-bit shadow and commits it atomically. Define TILE_CONFIG_LOADER_CHECKSUM_EN to add an XOR checksum byte.
module tile_config_loader #(
  parameter int         CONFIG_WIDTH = 146,
  parameter int         BYTE_COUNT   = 19,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_valid,
  output logic                    config_done,
  output logic                    error
);

  localparam int             CNT_W    = $clog2(BYTE_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTE_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_COMMIT
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CONFIG_WIDTH-1:0] shadow_q;
  logic [CONFIG_WIDTH-1:0] shadow_d;
  logic [CONFIG_WIDTH-1:0] config_q;
  logic                    ready_q;
  logic                    valid_q;
  logic                    done_q;
  logic                    accept;

  assign accept = data_valid && ready_q;

  // Drop the current byte into its slot; bits beyond CONFIG_WIDTH in the last byte fall away.
  always_comb begin
    // NOTE: default assignment first so no path leaves shadow_d unassigned, which would infer a latch.
    shadow_d = shadow_q;
    for (int b = 0; b < CONFIG_WIDTH; b++) begin
      if (cnt_q == CNT_W'(b / 8)) shadow_d[b] = data_in[3'(b % 8)];
    end
  end

`ifdef TILE_CONFIG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       err_q;
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    if (reset) begin
      // NOTE: the shadow is a plain register, not a RAM, so resetting it is cheap and keeps it deterministic.
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      config_q <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef TILE_CONFIG_LOADER_CHECKSUM_EN
      csum_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef TILE_CONFIG_LOADER_CHECKSUM_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (accept && data_in == SYNC_BYTE) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            shadow_q <= '0;
`ifdef TILE_CONFIG_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (accept) begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_q + 1'b1;
`ifdef TILE_CONFIG_LOADER_CHECKSUM_EN
            csum_q   <= csum_q ^ data_in;
            if (cnt_q == LAST_IDX) state_q <= ST_CHECK;
`else
            if (cnt_q == LAST_IDX) begin
              state_q <= ST_COMMIT;
              ready_q <= 1'b0;
            end
`endif
          end
        end
`ifdef TILE_CONFIG_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            if (data_in == csum_q) begin
              state_q <= ST_COMMIT;
              ready_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        ST_COMMIT: begin
          config_q <= shadow_q;
          done_q   <= 1'b1;
          valid_q  <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign data_ready   = ready_q;
  assign config_out   = config_q;
  assign config_valid = valid_q;
  assign config_done  = done_q;

endmodule
